raw_line_sequencer: RTL

- Sequences a raw Bayer pixel stream from the sensor capture into the debayer stage.
- Gates upstream pixels with a ready handshake and marks line boundaries with sop/eop.
- Enforces a minimum inter-line gap so the debayer line FIFOs can shift.
- After the last line of a frame, holds the stream off for a flush window so the debayer can drain its final line, then signals frame completion.

---
 rtl/raw_line_sequencer_if.sv | 28 ++
 rtl/raw_line_sequencer.sv | 133 +++++++++++++
 2 files changed

// File: rtl/raw_line_sequencer_if.sv
// Pixel stream bundle between sensor capture, the line sequencer and the debayer.
// master drives the raw pixel input side, slave is the sequencer.
// pix_* is valid/ready, raw_* is a valid-only registered output stream.
interface raw_line_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] pix_data;
    logic                  pix_valid;
    logic                  pix_fs;
    logic                  pix_ready;
    logic [DATA_WIDTH-1:0] raw_data;
    logic                  raw_valid;
    logic                  raw_sop;
    logic                  raw_eop;
    logic [11:0]           line_idx;

    modport master (
        output pix_data, pix_valid, pix_fs,
        input  pix_ready,
        input  raw_data, raw_valid, raw_sop, raw_eop, line_idx
    );

    modport slave (
        input  pix_data, pix_valid, pix_fs,
        output pix_ready,
        output raw_data, raw_valid, raw_sop, raw_eop, line_idx
    );
endinterface

// File: rtl/raw_line_sequencer.sv
// Sequences raw Bayer pixels into lines with sop/eop, inter-line gap and end-of-frame flush.
// Latency: 1 cycle from accept to raw_* (all outputs registered).
// Backpressure: pix_ready low in IDLE, GAP and FLUSH; upstream holds its pixel meanwhile.
module raw_line_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int H_ACTIVE     = 1280,
    parameter int V_ACTIVE     = 720,
    parameter int MIN_GAP      = 4,
    parameter int FLUSH_CYCLES = 100
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 err_clr,
    raw_line_sequencer_if.slave  stream,
    output logic                 frame_done,
    output logic                 frame_err
);

    typedef enum logic [2:0] {IDLE, WAIT_FS, LINE, GAP, FLUSH} state_t;

    localparam logic [11:0] COL_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [11:0] LINE_LAST  = 12'(V_ACTIVE - 1);
    localparam logic [9:0]  GAP_LOAD   = 10'(MIN_GAP - 1);
    localparam logic [9:0]  FLUSH_LOAD = 10'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [11:0] col;
    logic [11:0] line;
    logic [9:0]  cnt;
    logic        accept;

    assign accept = stream.pix_valid & stream.pix_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            col              <= '0;
            line             <= '0;
            cnt              <= '0;
            stream.pix_ready <= 1'b0;
            stream.raw_data  <= '0;
            stream.raw_valid <= 1'b0;
            stream.raw_sop   <= 1'b0;
            stream.raw_eop   <= 1'b0;
            stream.line_idx  <= '0;
            frame_done       <= 1'b0;
            frame_err        <= 1'b0;
        end else begin
            stream.raw_valid <= 1'b0;
            stream.raw_sop   <= 1'b0;
            stream.raw_eop   <= 1'b0;
            frame_done       <= 1'b0;
            // A set later in this block overrides the clear.
            if (err_clr) frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable) begin
                        state            <= WAIT_FS;
                        stream.pix_ready <= 1'b1;
                    end
                end
                WAIT_FS: begin
                    if (!enable) begin
                        state            <= IDLE;
                        stream.pix_ready <= 1'b0;
                    end else if (accept && stream.pix_fs) begin
                        stream.raw_valid <= 1'b1;
                        stream.raw_data  <= stream.pix_data;
                        stream.raw_sop   <= 1'b1;
                        stream.line_idx  <= '0;
                        col              <= 12'd1;
                        line             <= '0;
                        state            <= LINE;
                    end
                end
                LINE: begin
                    if (accept) begin
                        stream.raw_valid <= 1'b1;
                        stream.raw_data  <= stream.pix_data;
                        if (stream.pix_fs && (col != '0 || line != '0)) begin
                            // Early frame start: restart at line 0 without closing the cut line.
                            frame_err       <= 1'b1;
                            stream.raw_sop  <= 1'b1;
                            stream.line_idx <= '0;
                            col             <= 12'd1;
                            line            <= '0;
                        end else begin
                            stream.raw_sop  <= (col == '0);
                            stream.line_idx <= line;
                            if (col == COL_LAST) begin
                                stream.raw_eop   <= 1'b1;
                                stream.pix_ready <= 1'b0;
                                col              <= '0;
                                if (line == LINE_LAST) begin
                                    state      <= FLUSH;
                                    cnt        <= FLUSH_LOAD;
                                    frame_done <= (FLUSH_LOAD == 10'd0);
                                end else begin
                                    line  <= line + 12'd1;
                                    state <= GAP;
                                    cnt   <= GAP_LOAD;
                                end
                            end else begin
                                col <= col + 12'd1;
                            end
                        end
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state            <= LINE;
                        stream.pix_ready <= 1'b1;
                    end else begin
                        cnt <= cnt - 10'd1;
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state            <= enable ? WAIT_FS : IDLE;
                        stream.pix_ready <= enable;
                    end else begin
                        cnt        <= cnt - 10'd1;
                        frame_done <= (cnt == 10'd1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
